uart_rx_cfg: RTL and testbench
==============================

# uart_rx_cfg

Parametrised UART receiver: configurable data width, optional parity, one or two stop bits, with parity and framing error reporting. It sits between the external serial RX pin and the byte-level consumer, replacing the fixed 8N1 receiver. It adds an input synchronizer, a synchronous reset and a busy indication.

## Interface
- CLKS_PER_BIT, 104 — clock cycles per bit (i_Clock Hz / baud); legal ≥ 8
- DATA_BITS, 8 — data bits per frame; legal 5–9
- PARITY, 0 — 0 none, 1 odd, 2 even
- STOP_BITS, 1 — 1 or 2

- i_Clock  in  1  sole clock
- i_Reset  in  1  reset, synchronous, active-high
- i_RX_Serial  in  1  asynchronous serial line, idle high
- o_RX_DV  out  1  one-cycle pulse: frame complete, byte and flags valid
- o_RX_Byte  out  DATA_BITS  received data, LSB = first data bit on the wire
- o_Parity_Err  out  1  parity mismatch in the last frame (always 0 when PARITY=0)
- o_Frame_Err  out  1  a stop bit was sampled low in the last frame
- o_Busy  out  1  high in every state except IDLE

## Operation
- i_RX_Serial passes through a 2-flop synchronizer (reset to 1). All logic uses the synchronized value `rx_s` and its previous value `rx_q`.
- Constants:
  - M = (CLKS_PER_BIT-1)/2, integer division.
  - Counter width = $clog2(CLKS_PER_BIT).
  - Bit-index width = $clog2(DATA_BITS).
- States: IDLE, START, DATA, PARITY, STOP, CLEANUP. Any unused encoding goes to IDLE.
- IDLE:
  - Counter and index are cleared.
  - A falling edge (rx_q=1, rx_s=0) moves to START.
  - A line that is low without a prior high is ignored. A break or stuck-low line therefore never retriggers.
- START:
  - Count up to M, then sample the line.
  - Sample 0: clear the counter and go to DATA.
  - Sample 1: glitch; go to IDLE.
- DATA:
  - When the counter reaches CLKS_PER_BIT-1, sample the bit into position `index` and clear the counter.
  - After bit DATA_BITS-1, go to PARITY if PARITY≠0, otherwise go to STOP.
- PARITY:
  - Sample one bit.
  - Error if (XOR of data bits ^ sampled bit) ≠ 1 for odd parity.
  - Error if that value ≠ 0 for even parity.
- STOP:
  - Sample STOP_BITS bits, each at counter CLKS_PER_BIT-1.
  - Any stop bit sampled 0 sets the frame error.
  - After the last stop bit, go to CLEANUP.
- CLEANUP:
  - Lasts one cycle. o_RX_DV=1.
  - o_RX_Byte, o_Parity_Err and o_Frame_Err update this cycle and hold until the next CLEANUP.
  - Then go to IDLE.
- o_RX_DV is asserted for every completed frame, including errored ones. The flags qualify the data.
- A frame-error frame returns to IDLE normally. A new frame needs the line to go high, then low again.

## Timing
- Reset values:
  - o_RX_DV=0, o_RX_Byte=0, o_Parity_Err=0, o_Frame_Err=0, o_Busy=0.
  - State IDLE, counter 0, index 0.
  - Both synchronizer flops = 1.
- Reset takes priority over every state. Asserting reset mid-frame aborts the frame with no o_RX_DV pulse.
- Latency:
  - Pin-to-rx_s latency is 2 cycles.
  - The START state is entered 1 cycle after the falling edge on rx_s.
  - Let F = 1 + DATA_BITS + (PARITY≠0) + STOP_BITS bits per frame.
  - The last stop sample occurs M + (F-1)·CLKS_PER_BIT cycles after START entry.
  - o_RX_DV is high the cycle after that sample.
- Sample points sit at mid-bit ±½ cycle. The tolerated baud mismatch is about ±4% for 8N1.
- Back-to-back frames:
  - The receiver is in IDLE one cycle after the o_RX_DV pulse.
  - It accepts a start edge that arrives during the second half of the last stop bit, provided rx_s rose before the edge.

## Configuration
- UART_RX_MAJORITY_EN defined:
  - Every sample (start, data, parity, stop) is the 2-of-3 majority of rx_s at the sample cycle and the two cycles before it.
  - Sample cycles are unchanged.
  - Requires CLKS_PER_BIT ≥ 8.
- UART_RX_MAJORITY_EN undefined: every sample is the single rx_s value at the sample cycle.

## Test plan
- 8N1, CLKS_PER_BIT=16; send 0xA5.
  - Exactly one o_RX_DV pulse with o_RX_Byte=0xA5 and both error flags 0.
  - o_Busy is low after the pulse.
- PARITY=2, DATA_BITS=7; send 0x55 with a correct parity bit (0), then 0x55 with parity bit 1.
  - First frame: o_Parity_Err=0. Second frame: o_Parity_Err=1.
  - o_RX_Byte=0x55 both times.
- STOP_BITS=2; send 0x3C with the second stop bit low, then hold the line low for 3 bit times.
  - One o_RX_DV with o_Frame_Err=1 and o_RX_Byte=0x3C.
  - No further o_RX_DV until the line returns high and a new start edge arrives.
- Line low for M-2 cycles, then high.
  - No o_RX_DV and a return to IDLE.
  - A following valid frame with 0x81 is received correctly.
- Assert i_Reset for 1 cycle during data bit 4 of a frame, then send 0x0F.
  - No pulse for the aborted frame; all outputs are 0 after reset.
  - The following frame yields o_RX_Byte=0x0F.
- With UART_RX_MAJORITY_EN defined, inject a 1-cycle inverted glitch at the sample cycle of data bit 2 in 0xFF.
  - o_RX_Byte=0xFF.
  - Without the macro the same stimulus yields 0xFB.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// UART receiver with configurable data width, parity and stop bits.
// Define UART_RX_MAJORITY_EN to take every sample as a 2-of-3 vote over rx_s history.
module uart_rx_cfg #(
    parameter int CLKS_PER_BIT = 104,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset,
    input  logic                 i_RX_Serial,
    output logic                 o_RX_DV,
    output logic [DATA_BITS-1:0] o_RX_Byte,
    output logic                 o_Parity_Err,
    output logic                 o_Frame_Err,
    output logic                 o_Busy
);

    localparam int M     = (CLKS_PER_BIT - 1) / 2;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(M);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic             ODD_PAR   = (PARITY == 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_DATA    = 3'd2,
        S_PARITY  = 3'd3,
        S_STOP    = 3'd4,
        S_CLEANUP = 3'd5
    } state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [IDX_W-1:0] idx, idx_nx;
    logic             stop_idx, stop_nx;
    logic             smp_data, smp_par, smp_stop, done;

    logic                 rx_meta, rx_s, rx_q;
    logic                 sample_bit;
    logic [DATA_BITS-1:0] data_r;
    logic                 par_err_r, frm_err_r;

    // Stage: pin synchronizer and sample history
`ifdef UART_RX_MAJORITY_EN
    logic rx_qq;

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_q    <= 1'b1;
            rx_qq   <= 1'b1;
        end else begin
            rx_meta <= i_RX_Serial;
            rx_s    <= rx_meta;
            rx_q    <= rx_s;
            rx_qq   <= rx_q;
        end
    end

    assign sample_bit = (rx_s & rx_q) | (rx_s & rx_qq) | (rx_q & rx_qq);
`else
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_q    <= 1'b1;
        end else begin
            rx_meta <= i_RX_Serial;
            rx_s    <= rx_meta;
            rx_q    <= rx_s;
        end
    end

    assign sample_bit = rx_s;
`endif

    // Stage: frame sequencing
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            idx      <= '0;
            stop_idx <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            idx      <= idx_nx;
            stop_idx <= stop_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        idx_nx   = idx;
        stop_nx  = stop_idx;
        smp_data = 1'b0;
        smp_par  = 1'b0;
        smp_stop = 1'b0;
        done     = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_nx  = '0;
                idx_nx  = '0;
                stop_nx = 1'b0;
                // Only a true high-to-low transition starts a frame, so a stuck-low line never retriggers.
                if (rx_q && !rx_s) state_nx = S_START;
            end
            S_START: begin
                if (cnt == CNT_MID) begin
                    cnt_nx   = '0;
                    state_nx = sample_bit ? S_IDLE : S_DATA;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (cnt == CNT_LAST) begin
                    cnt_nx   = '0;
                    smp_data = 1'b1;
                    if (idx == IDX_LAST) begin
                        idx_nx   = '0;
                        state_nx = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        idx_nx = idx + 1'b1;
                    end
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            S_PARITY: begin
                if (cnt == CNT_LAST) begin
                    cnt_nx   = '0;
                    smp_par  = 1'b1;
                    state_nx = S_STOP;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            S_STOP: begin
                if (cnt == CNT_LAST) begin
                    cnt_nx   = '0;
                    smp_stop = 1'b1;
                    if (stop_idx == STOP_LAST) begin
                        done     = 1'b1;
                        state_nx = S_CLEANUP;
                    end else begin
                        stop_nx = 1'b1;
                    end
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            S_CLEANUP: state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
    end

    assign o_RX_DV = (state == S_CLEANUP);
    assign o_Busy  = (state != S_IDLE);

    // Stage: data capture and error accumulation
    always_ff @(posedge i_Clock) begin
        if (smp_data) data_r[idx] <= sample_bit;
        if (state == S_IDLE) begin
            par_err_r <= 1'b0;
            frm_err_r <= 1'b0;
        end else begin
            if (smp_par)  par_err_r <= (^data_r) ^ sample_bit ^ ODD_PAR;
            if (smp_stop && !sample_bit) frm_err_r <= 1'b1;
        end
    end

    // Stage: output registers, loaded on the final stop sample so they are valid with o_RX_DV
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            o_RX_Byte    <= '0;
            o_Parity_Err <= 1'b0;
            o_Frame_Err  <= 1'b0;
        end else if (done) begin
            o_RX_Byte    <= data_r;
            o_Parity_Err <= (PARITY != 0) ? par_err_r : 1'b0;
            o_Frame_Err  <= frm_err_r | ~sample_bit;
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: 8N1, 7E1 and 8N2 instances share one clock and reset.
module tb_uart_rx_cfg;

    localparam int CPB = 16;

    logic       clk;
    logic       rst;
    logic [2:0] rx_ln;

    logic       dv_a, pe_a, fe_a, busy_a;
    logic [7:0] byte_a;
    logic       dv_b, pe_b, fe_b, busy_b;
    logic [6:0] byte_b;
    logic       dv_c, pe_c, fe_c, busy_c;
    logic [7:0] byte_c;

    int checks = 0;
    int errors = 0;
    int dv_cnt [3];

    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
        .i_Clock(clk), .i_Reset(rst), .i_RX_Serial(rx_ln[0]), .o_RX_DV(dv_a), .o_RX_Byte(byte_a),
        .o_Parity_Err(pe_a), .o_Frame_Err(fe_a), .o_Busy(busy_a));

    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) dut_b (
        .i_Clock(clk), .i_Reset(rst), .i_RX_Serial(rx_ln[1]), .o_RX_DV(dv_b), .o_RX_Byte(byte_b),
        .o_Parity_Err(pe_b), .o_Frame_Err(fe_b), .o_Busy(busy_b));

    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) dut_c (
        .i_Clock(clk), .i_Reset(rst), .i_RX_Serial(rx_ln[2]), .o_RX_DV(dv_c), .o_RX_Byte(byte_c),
        .o_Parity_Err(pe_c), .o_Frame_Err(fe_c), .o_Busy(busy_c));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        dv_cnt[0] = 0;
        dv_cnt[1] = 0;
        dv_cnt[2] = 0;
    end

    always @(posedge clk) if (dv_a === 1'b1) dv_cnt[0] <= dv_cnt[0] + 1;
    always @(posedge clk) if (dv_b === 1'b1) dv_cnt[1] <= dv_cnt[1] + 1;
    always @(posedge clk) if (dv_c === 1'b1) dv_cnt[2] <= dv_cnt[2] + 1;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive n bits LSB first, one bit per CPB cycles; bit gbit gets a one-cycle inversion mid-bit.
    task automatic send_bits(input int sel, input logic [15:0] bits, input int n, input int gbit);
        for (int i = 0; i < n; i++) begin
            rx_ln[sel] = bits[i];
            if (i == gbit) begin
                repeat (8) @(negedge clk);
                rx_ln[sel] = ~bits[i];
                @(negedge clk);
                rx_ln[sel] = bits[i];
                repeat (7) @(negedge clk);
            end else begin
                repeat (CPB) @(negedge clk);
            end
        end
    endtask

    logic [15:0] glitch_exp;

    initial begin
`ifdef UART_RX_MAJORITY_EN
        glitch_exp = 16'h00FF;
`else
        glitch_exp = 16'h00FB;
`endif
        rx_ln = 3'b111;
        rst   = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        chk("reset_dv",   16'(dv_a),   16'h0);
        chk("reset_byte", 16'(byte_a), 16'h0);
        chk("reset_pe",   16'(pe_a),   16'h0);
        chk("reset_fe",   16'(fe_a),   16'h0);
        chk("reset_busy", 16'(busy_a), 16'h0);
        repeat (8) @(negedge clk);

        // 8N1 frame 0xA5
        send_bits(0, 16'({1'b1, 8'hA5, 1'b0}), 10, -1);
        repeat (2 * CPB) @(negedge clk);
        chk("a5_dvcnt", 16'(dv_cnt[0]), 16'd1);
        chk("a5_byte",  16'(byte_a),    16'h00A5);
        chk("a5_pe",    16'(pe_a),      16'h0);
        chk("a5_fe",    16'(fe_a),      16'h0);
        chk("a5_busy",  16'(busy_a),    16'h0);

        // 7E1: 0x55 has four ones, parity 0 is correct, parity 1 is wrong
        send_bits(1, 16'({1'b1, 1'b0, 7'h55, 1'b0}), 10, -1);
        repeat (2 * CPB) @(negedge clk);
        chk("par_ok_dvcnt", 16'(dv_cnt[1]), 16'd1);
        chk("par_ok_byte",  16'(byte_b),    16'h0055);
        chk("par_ok_pe",    16'(pe_b),      16'h0);
        send_bits(1, 16'({1'b1, 1'b1, 7'h55, 1'b0}), 10, -1);
        repeat (2 * CPB) @(negedge clk);
        chk("par_bad_dvcnt", 16'(dv_cnt[1]), 16'd2);
        chk("par_bad_byte",  16'(byte_b),    16'h0055);
        chk("par_bad_pe",    16'(pe_b),      16'h1);
        chk("par_bad_fe",    16'(fe_b),      16'h0);

        // 8N2 with second stop low, then the line stays low
        send_bits(2, 16'({1'b0, 1'b1, 8'h3C, 1'b0}), 11, -1);
        repeat (3 * CPB) @(negedge clk);
        chk("ferr_dvcnt", 16'(dv_cnt[2]), 16'd1);
        chk("ferr_fe",    16'(fe_c),      16'h1);
        chk("ferr_byte",  16'(byte_c),    16'h003C);
        repeat (3 * CPB) @(negedge clk);
        chk("ferr_stuck_dvcnt", 16'(dv_cnt[2]), 16'd1);
        rx_ln[2] = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        send_bits(2, 16'({2'b11, 8'h5A, 1'b0}), 11, -1);
        repeat (2 * CPB) @(negedge clk);
        chk("ferr_next_dvcnt", 16'(dv_cnt[2]), 16'd2);
        chk("ferr_next_byte",  16'(byte_c),    16'h005A);
        chk("ferr_next_fe",    16'(fe_c),      16'h0);

        // Short low pulse of M-2 = 5 cycles is rejected as a glitch
        rx_ln[0] = 1'b0;
        repeat (5) @(negedge clk);
        rx_ln[0] = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        chk("glitch_dvcnt", 16'(dv_cnt[0]), 16'd1);
        chk("glitch_busy",  16'(busy_a),    16'h0);
        send_bits(0, 16'({1'b1, 8'h81, 1'b0}), 10, -1);
        repeat (2 * CPB) @(negedge clk);
        chk("after_glitch_dvcnt", 16'(dv_cnt[0]), 16'd2);
        chk("after_glitch_byte",  16'(byte_a),    16'h0081);

        // Reset pulse in the middle of data bit 4 aborts the frame
        send_bits(0, 16'b11110, 5, -1);
        rx_ln[0] = 1'b1;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_dv",   16'(dv_a),   16'h0);
        chk("abort_byte", 16'(byte_a), 16'h0);
        chk("abort_pe",   16'(pe_a),   16'h0);
        chk("abort_fe",   16'(fe_a),   16'h0);
        chk("abort_busy", 16'(busy_a), 16'h0);
        repeat (4 * CPB) @(negedge clk);
        chk("abort_dvcnt", 16'(dv_cnt[0]), 16'd2);
        send_bits(0, 16'({1'b1, 8'h0F, 1'b0}), 10, -1);
        repeat (2 * CPB) @(negedge clk);
        chk("post_abort_dvcnt", 16'(dv_cnt[0]), 16'd3);
        chk("post_abort_byte",  16'(byte_a),    16'h000F);

        // 0xFF with a one-cycle low glitch on the data bit 2 sample cycle (wire bit 3)
        send_bits(0, 16'({1'b1, 8'hFF, 1'b0}), 10, 3);
        repeat (2 * CPB) @(negedge clk);
        chk("maj_dvcnt", 16'(dv_cnt[0]), 16'd4);
        chk("maj_byte",  16'(byte_a),    glitch_exp);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
